// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MEM/WB payload type and default widths.
// Used by pipe_stage_reg and its bench.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] mem_data;
    logic [DEF_DATA_W-1:0] alu_data;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_REG_AW-1:0] dst_reg;
    logic                  mem_to_reg;
    logic                  reg_write;
  } payload_t;

  function automatic int payload_w(
    input int dw,
    input int aw
  );
    return 2 * dw + 2 * aw + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one valid+payload register with load, clear, sync reset.
// Ports: ld/d load a beat, clr drops it (payload kept), vld/q hold it.
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (1'b1)
      clr: begin
        valid_d = 1'b0;
      end
      ld && !clr: begin
        valid_d = 1'b1;
        data_d  = d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign vld = valid_q;
  assign q   = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: MEM/WB register, valid/ready, 2-entry skid, flush.
// in_*/out_* handshake + payload, fwd_* live only with PIPE_STAGE_REG_FWD_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_dst_reg,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_dst_reg,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PW = payload_w(DATA_W, REG_AW);

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_pl;
  logic [PW-1:0] skid_pl;
  logic [PW-1:0] main_din;
  logic          main_v;
  logic          skid_v;
  logic          main_ld;
  logic          main_clr;
  logic          skid_ld;
  logic          skid_clr;
  logic          xfer_in;
  logic          main_en;
  logic          go;
  logic          rw_raw;

  assign in_pl = {
    in_mem_data, in_alu_data,
    in_rd, in_dst_reg,
    in_mem_to_reg, in_reg_write
  };

  assign in_ready = !skid_v;
  assign xfer_in  = in_valid & in_ready;
  assign main_en  = !main_v | out_ready;
  assign go       = !flush;

  // main_en with skid_v implies in_ready=0, so no input
  // transfer can race the skid drain.
  always_comb begin
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_din = in_pl;
    unique case (1'b1)
      flush: begin
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end
      go && main_en && skid_v: begin
        main_ld  = 1'b1;
        main_din = skid_pl;
        skid_clr = 1'b1;
      end
      go && main_en && !skid_v && xfer_in: begin
        main_ld = 1'b1;
      end
      go && main_en && !skid_v && !xfer_in: begin
        main_clr = 1'b1;
      end
      go && !main_en && xfer_in: begin
        skid_ld = 1'b1;
      end
      default: ;
    endcase
  end

  pipe_skid_entry #(
    .W(PW)
  ) u_main (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (main_ld),
    .clr  (main_clr),
    .d    (main_din),
    .vld  (main_v),
    .q    (main_pl)
  );

  pipe_skid_entry #(
    .W(PW)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (skid_ld),
    .clr  (skid_clr),
    .d    (in_pl),
    .vld  (skid_v),
    .q    (skid_pl)
  );

  assign {
    out_mem_data, out_alu_data,
    out_rd, out_dst_reg,
    out_mem_to_reg, rw_raw
  } = main_pl;

  assign out_valid     = main_v;
  assign out_reg_write = main_v & rw_raw;

`ifdef PIPE_STAGE_REG_FWD_EN
  assign fwd_valid = out_reg_write
                   & (out_dst_reg != '0);
  assign fwd_rd    = out_dst_reg;
  assign fwd_data  = out_mem_to_reg
                   ? out_mem_data
                   : out_alu_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table, corner sequences, random vs FIFO model.
// Build with PIPE_STAGE_REG_FWD_EN to exercise forwarding outputs.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mem_data;
  logic [31:0] in_alu_data;
  logic [4:0]  in_rd;
  logic [4:0]  in_dst_reg;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mem_data;
  logic [31:0] out_alu_data;
  logic [4:0]  out_rd;
  logic [4:0]  out_dst_reg;
  logic        out_mem_to_reg;
  logic        out_reg_write;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_data   (in_mem_data),
    .in_alu_data   (in_alu_data),
    .in_rd         (in_rd),
    .in_dst_reg    (in_dst_reg),
    .in_mem_to_reg (in_mem_to_reg),
    .in_reg_write  (in_reg_write),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mem_data  (out_mem_data),
    .out_alu_data  (out_alu_data),
    .out_rd        (out_rd),
    .out_dst_reg   (out_dst_reg),
    .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write (out_reg_write),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the stage is a 2-deep FIFO whose head is out_*.
  payload_t mq[$];
  bit       pl_zero;

  typedef struct {
    bit       rst;
    bit       fl;
    bit       iv;
    bit       ordy;
    bit [7:0] alu;
    bit       rw;
    bit       e_ov;
    bit       e_ir;
    bit [7:0] e_alu;
    bit       e_rw;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic payload_t mk(
    input bit [7:0] a,
    input bit       rw
  );
    payload_t p;
    p.mem_data   = 32'hC0FF_EE00 | {24'd0, a};
    p.alu_data   = {24'd0, a};
    p.rd         = a[4:0];
    p.dst_reg    = a[4:0] ^ 5'h1F;
    p.mem_to_reg = a[0];
    p.reg_write  = rw;
    return p;
  endfunction

  task automatic model_step(
    input bit       r,
    input bit       f,
    input bit       iv,
    input bit       ordy,
    input payload_t p
  );
    bit acc;
    if (!r) begin
      mq.delete();
      pl_zero = 1'b1;
    end else if (f) begin
      mq.delete();
    end else begin
      acc = iv && (mq.size() < 2);
      if (mq.size() > 0 && ordy)
        void'(mq.pop_front());
      if (acc) begin
        mq.push_back(p);
        pl_zero = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    payload_t e;
    bit       ov;
    bit       pl_chk;
    ov     = mq.size() > 0;
    pl_chk = ov || pl_zero;
    e      = ov ? mq[0] : '0;
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_reg_write", out_reg_write,
        ov && e.reg_write);
    if (pl_chk) begin
      chk("out_mem_data", out_mem_data, e.mem_data);
      chk("out_alu_data", out_alu_data, e.alu_data);
      chk("out_rd", out_rd, e.rd);
      chk("out_dst_reg", out_dst_reg, e.dst_reg);
      chk("out_mem_to_reg", out_mem_to_reg,
          e.mem_to_reg);
    end
`ifdef PIPE_STAGE_REG_FWD_EN
    chk("fwd_valid", fwd_valid,
        ov && e.reg_write && e.dst_reg != 0);
    if (pl_chk) begin
      chk("fwd_rd", fwd_rd, e.dst_reg);
      chk("fwd_data", fwd_data,
          e.mem_to_reg ? e.mem_data : e.alu_data);
    end
`else
    chk("fwd_valid", fwd_valid, 1'b0);
    chk("fwd_rd", fwd_rd, 5'd0);
    chk("fwd_data", fwd_data, 32'd0);
`endif
  endtask

  task automatic drive(
    input bit       r,
    input bit       f,
    input bit       iv,
    input bit       ordy,
    input payload_t p
  );
    rst_n         = r;
    flush         = f;
    in_valid      = iv;
    out_ready     = ordy;
    in_mem_data   = p.mem_data;
    in_alu_data   = p.alu_data;
    in_rd         = p.rd;
    in_dst_reg    = p.dst_reg;
    in_mem_to_reg = p.mem_to_reg;
    in_reg_write  = p.reg_write;
    @(posedge clk);
    model_step(r, f, iv, ordy, p);
    @(negedge clk);
    model_check();
  endtask

  task automatic add(
    input bit rst, input bit fl,
    input bit iv, input bit ordy,
    input bit [7:0] alu, input bit rw,
    input bit e_ov, input bit e_ir,
    input bit [7:0] e_alu, input bit e_rw
  );
    vec_t v;
    v.rst = rst; v.fl = fl;
    v.iv = iv; v.ordy = ordy;
    v.alu = alu; v.rw = rw;
    v.e_ov = e_ov; v.e_ir = e_ir;
    v.e_alu = e_alu; v.e_rw = e_rw;
    tbl.push_back(v);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_mem"}, out_mem_data, 32'd0);
    chk({tag, "_alu"}, out_alu_data, 32'd0);
    chk({tag, "_rd"}, out_rd, 5'd0);
    chk({tag, "_dst"}, out_dst_reg, 5'd0);
    chk({tag, "_m2r"}, out_mem_to_reg, 1'b0);
    chk({tag, "_fwd"}, {fwd_valid, fwd_rd, fwd_data},
        38'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    payload_t p;
    vec_t     v;
    pl_zero = 1'b1;

    // reset with a beat offered
    add(0,0,1,1,8'h99,1, 0,1,8'h00,0);
    add(0,0,1,1,8'h99,1, 0,1,8'h00,0);
    // streaming 8 beats
    for (int i = 0; i < 8; i++)
      add(1,0,1,1,8'h10+8'(i),1, 1,1,8'h10+8'(i),1);
    // bubble gates reg_write
    add(1,0,0,1,8'h00,0, 0,1,8'h00,0);
    // stall A,B,C then drain
    add(1,0,1,0,8'hA0,1, 1,1,8'hA0,1);
    add(1,0,1,0,8'hB0,0, 1,0,8'hA0,1);
    add(1,0,1,0,8'hC0,1, 1,0,8'hA0,1);
    add(1,0,1,1,8'hC0,1, 1,1,8'hB0,0);
    add(1,0,1,1,8'hC0,1, 1,1,8'hC0,1);
    add(1,0,0,1,8'h00,0, 0,1,8'h00,0);
    // flush with main and skid full
    add(1,0,1,0,8'hD0,1, 1,1,8'hD0,1);
    add(1,0,1,0,8'hE0,1, 1,0,8'hD0,1);
    add(1,1,0,0,8'h00,0, 0,1,8'h00,0);
    add(1,0,0,1,8'h00,0, 0,1,8'h00,0);
    // flush with out_ready and an input beat
    add(1,0,1,1,8'hF0,1, 1,1,8'hF0,1);
    add(1,1,1,1,8'hF1,1, 0,1,8'h00,0);
    add(1,0,0,1,8'h00,0, 0,1,8'h00,0);
    // reset mid-stall
    add(1,0,1,0,8'h30,1, 1,1,8'h30,1);
    add(1,0,1,0,8'h31,1, 1,0,8'h30,1);
    add(0,0,1,0,8'h32,1, 0,1,8'h00,0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.rst, v.fl, v.iv, v.ordy,
            mk(v.alu, v.rw));
      chk($sformatf("tbl%0d_ov", i),
          out_valid, v.e_ov);
      chk($sformatf("tbl%0d_ir", i),
          in_ready, v.e_ir);
      chk($sformatf("tbl%0d_rw", i),
          out_reg_write, v.e_rw);
      if (v.e_ov)
        chk($sformatf("tbl%0d_alu", i),
            out_alu_data, {24'd0, v.e_alu});
      if (i == 1 || i == tbl.size() - 1)
        zero_check($sformatf("tbl%0d_zero", i));
    end

    // forwarding beat
    p.mem_data   = 32'hDEAD_BEEF;
    p.alu_data   = 32'h1234_5678;
    p.rd         = 5'd3;
    p.dst_reg    = 5'd7;
    p.mem_to_reg = 1'b1;
    p.reg_write  = 1'b1;
    drive(1, 0, 1, 1, p);
`ifdef PIPE_STAGE_REG_FWD_EN
    chk("fwd7_valid", fwd_valid, 1'b1);
    chk("fwd7_rd", fwd_rd, 5'd7);
    chk("fwd7_data", fwd_data, 32'hDEAD_BEEF);
`else
    chk("fwd7_off", {fwd_valid, fwd_rd, fwd_data},
        38'd0);
`endif
    p.dst_reg = 5'd0;
    drive(1, 0, 1, 1, p);
    chk("fwd0_valid", fwd_valid, 1'b0);
    chk("fwd0_rw", out_reg_write, 1'b1);
    p.dst_reg    = 5'd9;
    p.mem_to_reg = 1'b0;
    drive(1, 0, 1, 1, p);
`ifdef PIPE_STAGE_REG_FWD_EN
    chk("fwd9_data", fwd_data, 32'h1234_5678);
`endif
    drive(1, 0, 0, 1, p);
    chk("fwd_bubble", fwd_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      p.mem_data   = $urandom;
      p.alu_data   = $urandom;
      p.rd         = 5'($urandom);
      p.dst_reg    = 5'($urandom_range(0, 3));
      p.mem_to_reg = 1'($urandom);
      p.reg_write  = 1'($urandom);
      drive($urandom_range(0, 63) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            p);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised MEM/WB pipeline stage register with valid/ready flow control, a 2-entry skid buffer, synchronous flush and a gated register-write strobe. It sits between the memory stage and the write-back stage, carrying memory read data, ALU result, destination register fields and write-back controls. Unlike a free-running latch, it can hold a beat while write-back stalls, kill in-flight beats on flush, and never loses or duplicates a beat.

## Interface
Parameters:
- DATA_W, 32, width of memory and ALU data fields
- REG_AW, 5, width of register address fields

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill all held beats this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_mem_data  in  DATA_W  memory read result
- in_alu_data  in  DATA_W  ALU result
- in_rd  in  REG_AW  Rd field
- in_dst_reg  in  REG_AW  selected destination register
- in_mem_to_reg  in  1  write-back selects memory data
- in_reg_write  in  1  write-back enable
- out_valid  out  1  held beat present
- out_ready  in  1  downstream consumes the beat
- out_mem_data, out_alu_data  out  DATA_W  held payload
- out_rd, out_dst_reg  out  REG_AW  held payload
- out_mem_to_reg  out  1  held control
- out_reg_write  out  1  held reg_write AND out_valid
- fwd_valid  out  1  forwarding result valid
- fwd_rd  out  REG_AW  forwarding destination
- fwd_data  out  DATA_W  forwarding value

## Operation
- Two entries: main (drives out_*) and skid. Each entry has a valid bit and a payload.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = !skid_valid, taken straight from the skid register.
- Main loads when !main_valid or out_ready:
  - from skid if skid_valid, which also clears skid;
  - else from input on an input transfer;
  - else main_valid goes to 0.
- If main is valid, out_ready=0, and an input transfer occurs, the beat goes to skid.
- Beat order is strictly FIFO. No beat is dropped or duplicated except by flush.
- flush has priority over everything:
  - main_valid and skid_valid clear next edge;
  - any beat transferred in the flush cycle is discarded;
  - payload registers keep their old value.
- out_reg_write is forced 0 whenever out_valid=0, so a bubble or flushed beat never writes the register file.
- Payloads pass through unmodified. No arithmetic.

## Timing
- Reset (rst_n=0 at an edge): valid bits 0 and all payload registers 0.
  - Resulting outputs: out_valid=0, out_reg_write=0, fwd_valid=0, in_ready=1, all out_* and fwd_* zero.
  - Beats presented during reset are dropped.
- Latency is 1 cycle: an input beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat/cycle with out_ready held high.
- Stall at full occupancy:
  - one extra beat is absorbed into skid;
  - in_ready falls the cycle after skid fills;
  - in_ready rises the cycle after skid drains into main.
- out_ready rising while skid is full: main takes skid, skid empties, and in_ready=1 on the following cycle.
- flush together with out_ready=1: the beat currently on out_* is consumed by downstream (that transfer stands); nothing else survives.
- Reset mid-stall is equivalent to flush plus payload zeroing.

## Configuration
- Macro: PIPE_STAGE_REG_FWD_EN.
- Defined:
  - fwd_valid = out_valid & out_reg_write & (out_dst_reg != 0);
  - fwd_rd = out_dst_reg;
  - fwd_data = out_mem_to_reg ? out_mem_data : out_alu_data.
  - These are combinational from the main entry, for the EX-stage forwarding unit.
- Undefined: fwd_valid, fwd_rd and fwd_data are tied to 0. The ports remain present so the interface does not change.

## Structure
- Shared package pipe_pkg holds:
  - the packed payload typedef (mem_data, alu_data, rd, dst_reg, mem_to_reg, reg_write);
  - the default DATA_W and REG_AW constants.
- One sub-module, pipe_skid_entry: a single valid+payload register with load, clear and synchronous reset. It is instantiated twice (main and skid).

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> after release out_valid=0, out_reg_write=0, in_ready=1, all outputs 0.
- Streaming: 8 beats, alu_data=0x10..0x17, out_ready=1 -> each beat appears one cycle after acceptance, in order, no gaps.
- Stall: out_ready=0 while 3 beats (A, B, C) are offered:
  - A is held in main, B goes to skid, in_ready=0, and C is held by the source;
  - after out_ready=1, the outputs are A, B, C in consecutive cycles.
- Flush: flush=1 with main=A and skid=B and out_ready=0 -> next cycle out_valid=0, out_reg_write=0, in_ready=1; A and B are never output.
- Gating: beat with reg_write=1 followed by a bubble -> out_reg_write=1 for one cycle, then 0.
- Forwarding (macro defined): beat with dst_reg=7, mem_to_reg=1, mem_data=0xDEADBEEF, reg_write=1 -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEADBEEF. The same beat with dst_reg=0 gives fwd_valid=0.
